pc_interface_read_bank_burst: RTL and testbench
===============================================

Name: pc_interface_read_bank_burst

Overview:
Successor to the PC-interface read bank. Freezes all 2^ADDR_WIDTH monitored words into shadow registers on a snapshot strobe, so every word in the set comes from the same cycle. It then streams a programmable run of words to the PC interface serializer over a valid/ready handshake. It sits between the signal-generator status/measurement buses and the PC interface TX path.

Parameters:
DATA_WIDTH, 16, width of one word
ADDR_WIDTH, 3, log2 of word count (bank holds 2^ADDR_WIDTH words)
LEN_WIDTH, ADDR_WIDTH+1, width of burst length field

Ports:
i_clk  in  1  system clock, all logic rising-edge
i_arst  in  1  asynchronous reset, active-high
i_data  in  DATA_WIDTH<<ADDR_WIDTH  live words packed, word k at [(k+1)*DATA_WIDTH-1:k*DATA_WIDTH]
i_snap  in  1  snapshot strobe, capture all words
i_rd_start  in  1  start burst (single-cycle pulse)
i_rd_addr  in  ADDR_WIDTH  first word of burst
i_rd_len  in  LEN_WIDTH  number of words; 0 means 2^ADDR_WIDTH
o_rd_busy  out  1  burst in progress
o_data  out  DATA_WIDTH  current stream word
o_valid  out  1  o_data valid
i_ready  in  1  consumer accepts o_data
o_last  out  1  marks final word of burst
o_snap_miss  out  1  1-cycle pulse: i_snap ignored during a burst

Behaviour:
- Reset (i_arst=1, async): all shadows 0, o_data 0, o_valid 0, o_last 0, o_rd_busy 0, o_snap_miss 0, pointer/counter 0, state IDLE.
- States: IDLE, STREAM.
- IDLE:
  - i_snap=1 → all shadows <= i_data slices in that cycle.
  - i_rd_start=1 → latch ptr=i_rd_addr and rem=(i_rd_len==0 ? 2^ADDR_WIDTH : i_rd_len).
  - Also on i_rd_start: o_data <= word[i_rd_addr], o_valid<=1, o_last<=(rem==1), o_rd_busy<=1, then go to STREAM. Latency start→o_valid = 1 cycle.
- Simultaneous i_snap and i_rd_start in IDLE: capture happens and the burst returns the newly captured data. The first o_data comes from the i_data slice directly, not the old shadow.
- STREAM:
  - Handshake is o_valid&&i_ready.
  - On handshake with rem>1: ptr<=ptr+1 modulo 2^ADDR_WIDTH (wraps 2^ADDR_WIDTH-1→0), rem<=rem-1, o_data<=shadow[ptr+1], o_last<=(rem==2).
  - On handshake with rem==1 (o_last=1): o_valid<=0, o_last<=0, o_rd_busy<=0, go to IDLE. o_data holds its last value.
  - While o_valid&&!i_ready: o_data, o_last held stable; no advance.
- Shadows are frozen during STREAM:
  - i_snap in STREAM is ignored and o_snap_miss pulses 1 cycle.
  - i_rd_start in STREAM is ignored; there is no queuing.
- i_ready is don't-care while o_valid=0.
- A new burst may start in the cycle after the return to IDLE; there is no back-to-back start within the same cycle.
- Length arithmetic: rem is a LEN_WIDTH unsigned down-counter. A length of 2^ADDR_WIDTH reads every word once, starting at i_rd_addr and wrapping.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values; shadows cleared.

Optional Feature:
Macro READ_BANK_CHANGE_FLAG_EN.
- Defined:
  - Adds output o_chg_flags, width 2^ADDR_WIDTH.
  - On an accepted snapshot, bit k is set if the new word k differs from the previous shadow k.
  - Bit k clears on the handshake that delivers word k.
  - Reset value is all 0.
  - A snapshot and a clear cannot coincide, because snapshots are ignored in STREAM.
- Not defined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset mid-STREAM (i_arst pulse during word 2 of 4) → o_valid/o_rd_busy/o_data 0 asynchronously; shadows 0; a fresh start afterwards returns 0x0000 words.
- Snap, then burst in a later cycle: i_data words k=0x1000+k (words 0..7), i_snap, later i_rd_addr=2, i_rd_len=3, i_ready=1 → o_valid one cycle after start. Data 0x1002, 0x1003, 0x1004 on consecutive cycles, o_last on 0x1004, o_rd_busy low next cycle.
- Wrap and len=0: shadows 0xA0..0xA7, i_rd_addr=6, i_rd_len=0 → 8 words 0xA6, 0xA7, 0xA0..0xA5, o_last only on 0xA5.
- Backpressure: i_ready toggled 1/0 randomly during a 5-word burst → each word appears exactly once, in order, and is stable while i_ready=0.
- Coincident and ignored strobes:
  - i_snap and i_rd_start in the same IDLE cycle with new i_data=0x5555 at addr 0 → first word 0x5555.
  - i_snap during STREAM → o_snap_miss 1-cycle pulse, streamed words unchanged.
  - i_rd_start during STREAM → no effect.
- READ_BANK_CHANGE_FLAG_EN:
  - Two snapshots where only word 3 changes → o_chg_flags=0x08.
  - A burst covering addr 3 → flag clears on that handshake.

Source files
------------

// File: rtl/pc_interface_read_bank_burst.sv
// rtl/pc_interface_read_bank_burst.sv - snapshot shadow bank streamed as bursts over valid/ready
// Optional change flags per word: define READ_BANK_CHANGE_FLAG_EN.
module pc_interface_read_bank_burst #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                               i_clk,
    input  logic                               i_arst,
    input  logic [(DATA_WIDTH<<ADDR_WIDTH)-1:0] i_data,
    input  logic                               i_snap,
    input  logic                               i_rd_start,
    input  logic [ADDR_WIDTH-1:0]              i_rd_addr,
    input  logic [LEN_WIDTH-1:0]               i_rd_len,
    output logic                               o_rd_busy,
    output logic [DATA_WIDTH-1:0]              o_data,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic                               o_last,
    output logic                               o_snap_miss
`ifdef READ_BANK_CHANGE_FLAG_EN
    ,
    output logic [(1<<ADDR_WIDTH)-1:0]         o_chg_flags
`endif
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shadow_q [WORDS];
    logic [DATA_WIDTH-1:0]   shadow_d [WORDS];
    logic [DATA_WIDTH-1:0]   live     [WORDS];
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d, rem_start;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    miss_q, miss_d;
`ifdef READ_BANK_CHANGE_FLAG_EN
    logic [WORDS-1:0]        flags_q, flags_d;
`endif

    always_comb begin
        for (int k = 0; k < WORDS; k++) begin
            live[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            for (int k = 0; k < WORDS; k++) begin
                shadow_q[k] <= '0;
            end
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            miss_q  <= 1'b0;
`ifdef READ_BANK_CHANGE_FLAG_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            for (int k = 0; k < WORDS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            miss_q  <= miss_d;
`ifdef READ_BANK_CHANGE_FLAG_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign rem_start = (i_rd_len == '0) ? LEN_WIDTH'(WORDS) : i_rd_len;

    always_comb begin
        state_d = state_q;
        for (int k = 0; k < WORDS; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        miss_d  = 1'b0;
`ifdef READ_BANK_CHANGE_FLAG_EN
        flags_d = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_snap) begin
                    for (int k = 0; k < WORDS; k++) begin
                        shadow_d[k] = live[k];
`ifdef READ_BANK_CHANGE_FLAG_EN
                        flags_d[k] = (live[k] != shadow_q[k]);
`endif
                    end
                end
                if (i_rd_start) begin
                    ptr_d   = i_rd_addr;
                    rem_d   = rem_start;
                    // A coincident snapshot must be visible in the very first word.
                    data_d  = i_snap ? live[i_rd_addr] : shadow_q[i_rd_addr];
                    valid_d = 1'b1;
                    last_d  = (rem_start == LEN_WIDTH'(1));
                    busy_d  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                miss_d = i_snap;
                if (valid_q && i_ready) begin
`ifdef READ_BANK_CHANGE_FLAG_EN
                    flags_d[ptr_q] = 1'b0;
`endif
                    if (rem_q > LEN_WIDTH'(1)) begin
                        ptr_d  = ptr_q + ADDR_WIDTH'(1);
                        rem_d  = rem_q - LEN_WIDTH'(1);
                        data_d = shadow_q[ptr_q + ADDR_WIDTH'(1)];
                        last_d = (rem_q == LEN_WIDTH'(2));
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rd_busy   = busy_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_last      = last_q;
    assign o_snap_miss = miss_q;
`ifdef READ_BANK_CHANGE_FLAG_EN
    assign o_chg_flags = flags_q;
`endif

endmodule

// File: tb/tb_pc_interface_read_bank_burst.sv
// tb/tb_pc_interface_read_bank_burst.sv - directed self-checking bench for the read bank burst
module tb_pc_interface_read_bank_burst;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int LW = AW + 1;
    localparam int NW = 1 << AW;

    logic              clk;
    logic              arst;
    logic [(DW<<AW)-1:0] data_in;
    logic              snap;
    logic              rd_start;
    logic [AW-1:0]     rd_addr;
    logic [LW-1:0]     rd_len;
    logic              rd_busy;
    logic [DW-1:0]     data_out;
    logic              valid;
    logic              ready;
    logic              last;
    logic              snap_miss;
`ifdef READ_BANK_CHANGE_FLAG_EN
    logic [NW-1:0]     chg_flags;
`endif

    int total = 0;
    int bad   = 0;

    pc_interface_read_bank_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .i_clk       (clk),
        .i_arst      (arst),
        .i_data      (data_in),
        .i_snap      (snap),
        .i_rd_start  (rd_start),
        .i_rd_addr   (rd_addr),
        .i_rd_len    (rd_len),
        .o_rd_busy   (rd_busy),
        .o_data      (data_out),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_last      (last),
        .o_snap_miss (snap_miss)
`ifdef READ_BANK_CHANGE_FLAG_EN
        ,
        .o_chg_flags (chg_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [DW-1:0] base);
        for (int k = 0; k < NW; k++) begin
            data_in[k*DW +: DW] = base + DW'(k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic r;
        arst = 1'b1; data_in = '0; snap = 0; rd_start = 0; rd_addr = '0; rd_len = '0; ready = 0;
        #12;
        chk("rst_valid", valid, 0);
        chk("rst_busy", rd_busy, 0);
        chk("rst_data", data_out, 0);
        chk("rst_last", last, 0);
        chk("rst_miss", snap_miss, 0);
        arst = 1'b0;

        // snap, then burst later; live data changes after the snap
        set_words(16'h1000); snap = 1; step(); snap = 0;
        set_words(16'hF000); step();
        rd_start = 1; rd_addr = 2; rd_len = 3; ready = 1; step(); rd_start = 0;
        chk("b1_valid", valid, 1);
        chk("b1_busy", rd_busy, 1);
        chk("b1_w0", data_out, 16'h1002);
        chk("b1_l0", last, 0);
        step();
        chk("b1_w1", data_out, 16'h1003);
        chk("b1_l1", last, 0);
        step();
        chk("b1_w2", data_out, 16'h1004);
        chk("b1_l2", last, 1);
        step();
        chk("b1_end_busy", rd_busy, 0);
        chk("b1_end_valid", valid, 0);
        chk("b1_end_hold", data_out, 16'h1004);

        // wrap with len=0 (whole bank)
        set_words(16'h00A0); snap = 1; step(); snap = 0;
        rd_start = 1; rd_addr = 6; rd_len = 0; ready = 1; step(); rd_start = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap_w%0d", i), data_out, 16'h00A0 + 16'((6 + i) % 8));
            chk($sformatf("wrap_l%0d", i), last, (i == 7) ? 1 : 0);
            step();
        end
        chk("wrap_end_busy", rd_busy, 0);

        // backpressure, 5 words from addr 1
        rd_start = 1; rd_addr = 1; rd_len = 5; ready = 0; step(); rd_start = 0;
        idx = 0;
        for (int c = 0; c < 80 && idx < 5; c++) begin
            chk("bp_valid", valid, 1);
            chk($sformatf("bp_w%0d", idx), data_out, 16'h00A0 + 16'(1 + idx));
            chk($sformatf("bp_l%0d", idx), last, (idx == 4) ? 1 : 0);
            r = 1'($urandom_range(0, 1));
            ready = r;
            step();
            if (r) idx++;
        end
        chk("bp_count", idx, 5);
        chk("bp_end_busy", rd_busy, 0);
        chk("bp_end_valid", valid, 0);

        // snap and start during STREAM are ignored
        ready = 0; rd_start = 1; rd_addr = 0; rd_len = 4; step(); rd_start = 0;
        chk("ign_w0", data_out, 16'h00A0);
        set_words(16'h7770); snap = 1; rd_start = 1; rd_addr = 5; rd_len = 1; step();
        snap = 0; rd_start = 0;
        chk("ign_miss", snap_miss, 1);
        chk("ign_hold", data_out, 16'h00A0);
        chk("ign_last", last, 0);
        step();
        chk("ign_miss_clr", snap_miss, 0);
        ready = 1; step();
        chk("ign_w1", data_out, 16'h00A1);
        step();
        chk("ign_w2", data_out, 16'h00A2);
        step();
        chk("ign_w3", data_out, 16'h00A3);
        chk("ign_l3", last, 1);
        step();
        chk("ign_end_busy", rd_busy, 0);
        rd_start = 1; rd_addr = 0; rd_len = 1; step(); rd_start = 0;
        chk("ign_shadow", data_out, 16'h00A0);
        chk("ign_shadow_last", last, 1);
        step();

        // coincident snap and start
        set_words(16'h5555); snap = 1; rd_start = 1; rd_addr = 0; rd_len = 2; ready = 1; step();
        snap = 0; rd_start = 0;
        chk("co_w0", data_out, 16'h5555);
        chk("co_l0", last, 0);
        step();
        chk("co_w1", data_out, 16'h5556);
        chk("co_l1", last, 1);
        step();
        chk("co_end_busy", rd_busy, 0);

`ifdef READ_BANK_CHANGE_FLAG_EN
        data_in[3*DW +: DW] = 16'hBEEF; snap = 1; step(); snap = 0;
        chk("flag_set", chg_flags, 8'h08);
        rd_start = 1; rd_addr = 2; rd_len = 2; ready = 1; step(); rd_start = 0;
        step();
        chk("flag_hold", chg_flags, 8'h08);
        chk("flag_w3", data_out, 16'hBEEF);
        step();
        chk("flag_clr", chg_flags, 8'h00);
`endif

        // async reset mid-burst
        rd_start = 1; rd_addr = 0; rd_len = 4; ready = 1; step(); rd_start = 0;
        step();
        #2 arst = 1'b1;
        #1;
        chk("ar_valid", valid, 0);
        chk("ar_busy", rd_busy, 0);
        chk("ar_data", data_out, 0);
        chk("ar_last", last, 0);
        #1 arst = 1'b0;
        rd_start = 1; rd_addr = 0; rd_len = 2; ready = 1; step(); rd_start = 0;
        chk("ar_w0", data_out, 0);
        chk("ar_v0", valid, 1);
        step();
        chk("ar_w1", data_out, 0);
        chk("ar_l1", last, 1);
        step();
        chk("ar_end_busy", rd_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
